// File: rtl/register_access_master_if.sv
`timescale 1ns/1ps
// register_access_master_if
// Bundles the request, TX payload stream, RX payload stream and response
// signals of the register-access master. Clock and reset stay outside.
//   master modport : the register_access_master itself
//   slave  modport : the surrounding logic (host request side, UDP TX/RX ports)
// Signal names keep their i_/o_ prefixes as seen from the master.
interface register_access_master_if #(
  parameter int REG_WIDTH = 32
) ();
  // request side
  logic                 i_req_valid;
  logic                 o_req_ready;
  logic                 i_req_write;
  logic [2:0]           i_req_reg;
  logic [REG_WIDTH-1:0] i_req_wdata;
  // UDP TX payload stream
  logic [7:0]           o_tx_tdata;
  logic                 o_tx_tvalid;
  logic                 o_tx_tlast;
  logic                 i_tx_tready;
  // UDP RX payload stream
  logic [7:0]           i_rx_tdata;
  logic                 i_rx_tvalid;
  logic                 i_rx_tlast;
  logic                 o_rx_tready;
  // response side
  logic                 o_rsp_valid;
  logic [REG_WIDTH-1:0] o_rsp_rdata;
  logic                 o_rsp_error;
  logic                 o_busy;

  modport master (
    input  i_req_valid, i_req_write, i_req_reg, i_req_wdata,
    input  i_tx_tready, i_rx_tdata, i_rx_tvalid, i_rx_tlast,
    output o_req_ready, o_tx_tdata, o_tx_tvalid, o_tx_tlast,
    output o_rx_tready, o_rsp_valid, o_rsp_rdata, o_rsp_error, o_busy
  );

  modport slave (
    output i_req_valid, i_req_write, i_req_reg, i_req_wdata,
    output i_tx_tready, i_rx_tdata, i_rx_tvalid, i_rx_tlast,
    input  o_req_ready, o_tx_tdata, o_tx_tvalid, o_tx_tlast,
    input  o_rx_tready, o_rsp_valid, o_rsp_rdata, o_rsp_error, o_busy
  );
endinterface

// File: rtl/register_access_master.sv
`timescale 1ns/1ps
// register_access_master
// Turns a local register read/write request into the ASCII-framed payload
// ":<n>W<data MSB first>" or ":<n>R" on the UDP TX stream, and for reads
// collects NB returned bytes (MSB first) from the UDP RX stream.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : register_access_master_if.master (request, TX, RX, response)
// Every output is a flop; the output values are computed from the next state,
// so a request accepted in cycle T shows its first TX byte in T+1.
module register_access_master #(
  parameter int REGS_NUM       = 4,
  parameter int REG_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic i_clk,
  input  logic i_rst,
  register_access_master_if.master bus
);
  localparam int NB    = REG_WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_COLON, S_SEND_NBR, S_SEND_CMD, S_SEND_DATA, S_WAIT_RSP, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 write_q, write_d;
  logic [2:0]           reg_q, reg_d;
  // Write data shifted out MSB first, or read data accumulated MSB first.
  logic [REG_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [31:0]          tmo_q, tmo_d;
  // Result of the transaction, valid when the next state is S_DONE.
  logic                 fin_err;
  logic [REG_WIDTH-1:0] fin_rdata;

  logic                 req_ready_q, req_ready_d;
  logic                 rx_tready_q, rx_tready_d;
  logic                 tx_tvalid_q, tx_tvalid_d;
  logic                 tx_tlast_q, tx_tlast_d;
  logic [7:0]           tx_tdata_q, tx_tdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_error_q, rsp_error_d;
  logic [REG_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 busy_q, busy_d;

  logic tx_hs, rx_hs, last_idx;
  assign tx_hs    = tx_tvalid_q && bus.i_tx_tready;
  assign rx_hs    = rx_tready_q && bus.i_rx_tvalid;
  assign last_idx = (idx_q == IDX_W'(NB - 1));

  // Framing is by byte count only, so the RX last flag is deliberately unused.
  logic unused_rx_tlast;
  assign unused_rx_tlast = bus.i_rx_tlast;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      reg_q       <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      req_ready_q <= 1'b0;
      rx_tready_q <= 1'b0;
      tx_tvalid_q <= 1'b0;
      tx_tlast_q  <= 1'b0;
      tx_tdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      req_ready_q <= req_ready_d;
      rx_tready_q <= rx_tready_d;
      tx_tvalid_q <= tx_tvalid_d;
      tx_tlast_q  <= tx_tlast_d;
      tx_tdata_q  <= tx_tdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    reg_d     = reg_q;
    data_d    = data_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    fin_err   = 1'b0;
    fin_rdata = '0;
    case (state_q)
      S_IDLE: begin
        if (req_ready_q && bus.i_req_valid) begin
          write_d = bus.i_req_write;
          reg_d   = bus.i_req_reg;
          data_d  = bus.i_req_wdata;
          idx_d   = '0;
          if (int'(bus.i_req_reg) >= REGS_NUM) begin
            state_d = S_DONE;
            fin_err = 1'b1;
          end else begin
            state_d = S_SEND_COLON;
          end
        end
      end
      S_SEND_COLON: if (tx_hs) state_d = S_SEND_NBR;
      S_SEND_NBR:   if (tx_hs) state_d = S_SEND_CMD;
      S_SEND_CMD: begin
        if (tx_hs) begin
          if (write_q) begin
            state_d = S_SEND_DATA;
          end else begin
            state_d = S_WAIT_RSP;
            tmo_d   = '0;
            idx_d   = '0;
            data_d  = '0;
          end
        end
      end
      S_SEND_DATA: begin
        if (tx_hs) begin
          if (last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = data_q << 8;
          end
        end
      end
      S_WAIT_RSP: begin
        if (rx_hs) begin
          data_d = (data_q << 8) | REG_WIDTH'(bus.i_rx_tdata);
          idx_d  = idx_q + 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
        // The final byte beats a timeout expiring in the same cycle.
        if (rx_hs && last_idx) begin
          state_d   = S_DONE;
          fin_rdata = data_d;
        end else if (tmo_q >= 32'(TIMEOUT_CYCLES)) begin
          state_d = S_DONE;
          fin_err = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: registered outputs derived from the next state, so a
  // stalled TX byte is recomputed identically and stays stable.
  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    rx_tready_d = (state_d == S_IDLE) || (state_d == S_WAIT_RSP);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
    rsp_error_d = rsp_valid_d ? fin_err   : rsp_error_q;
    rsp_rdata_d = rsp_valid_d ? fin_rdata : rsp_rdata_q;
    tx_tvalid_d = 1'b0;
    tx_tlast_d  = 1'b0;
    tx_tdata_d  = 8'h00;
    case (state_d)
      S_SEND_COLON: begin
        tx_tvalid_d = 1'b1;
        tx_tdata_d  = 8'h3A;
      end
      S_SEND_NBR: begin
        tx_tvalid_d = 1'b1;
        tx_tdata_d  = 8'h30 + {5'd0, reg_d};
      end
      S_SEND_CMD: begin
        tx_tvalid_d = 1'b1;
        tx_tdata_d  = write_d ? 8'h57 : 8'h52;
        tx_tlast_d  = !write_d;
      end
      S_SEND_DATA: begin
        tx_tvalid_d = 1'b1;
        tx_tdata_d  = data_d[REG_WIDTH-1 -: 8];
        tx_tlast_d  = (idx_d == IDX_W'(NB - 1));
      end
      default: ;
    endcase
  end

  assign bus.o_req_ready = req_ready_q;
  assign bus.o_rx_tready = rx_tready_q;
  assign bus.o_tx_tvalid = tx_tvalid_q;
  assign bus.o_tx_tlast  = tx_tlast_q;
  assign bus.o_tx_tdata  = tx_tdata_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_error = rsp_error_q;
  assign bus.o_rsp_rdata = rsp_rdata_q;
  assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_register_access_master.sv
`timescale 1ns/1ps
// Testbench for register_access_master (REGS_NUM=4, REG_WIDTH=32,
// TIMEOUT_CYCLES=16). Each transaction is driven cycle by cycle; the expected
// frame, response cycle and result come from a frame/timing model of the
// protocol applied to the stimulus the bench itself chose.
module tb_register_access_master;
  localparam int REGS = 4;
  localparam int RW   = 32;
  localparam int NB   = RW / 8;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  register_access_master_if #(.REG_WIDTH(RW)) bus ();

  register_access_master #(.REGS_NUM(REGS), .REG_WIDTH(RW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // current request (stimulus)
  bit          cur_wr;
  logic [2:0]  cur_rg;
  logic [31:0] cur_wd, cur_rxw;
  int          cur_rxn;
  int          cur_dly[4];
  bit          tr_hist[$];
  // observations
  string       obs_frame;
  int          obs_rsp_cyc, obs_stall_bad;
  bit          obs_rsp_err, obs_ready_t0, obs_ready_t1, obs_tvalid_t1, obs_busy_t1;
  bit          obs_after_valid, obs_after_ready;
  logic [31:0] obs_rsp_data, obs_after_data;
  // model expectations
  string       exp_frame;
  int          exp_cyc;
  bit          exp_err;
  logic [31:0] exp_data;

  // Protocol model: frame bytes, then response cycle (relative to request
  // cycle T=0) from the tready pattern and the responder byte delays.
  function automatic void build_exp();
    byte unsigned b[$];
    int cnt, last, e, cum;
    exp_frame = "";
    exp_err   = 1'b0;
    exp_data  = 32'h0;
    exp_cyc   = -1;
    if (int'(cur_rg) >= REGS) begin
      exp_err = 1'b1;
      exp_cyc = 1;
      return;
    end
    b.push_back(8'h3A);
    b.push_back(8'h30 + 8'(cur_rg));
    b.push_back(cur_wr ? 8'h57 : 8'h52);
    if (cur_wr) for (int i = 0; i < NB; i++) b.push_back(8'(cur_wd >> (8 * (NB - 1 - i))));
    foreach (b[i]) exp_frame = {exp_frame, $sformatf("%02h%s ", b[i], (i == b.size() - 1) ? "*" : "")};
    cnt = 0;
    last = -1;
    foreach (tr_hist[i]) if (tr_hist[i] && last < 0) begin
      cnt++;
      if (cnt == b.size()) last = i + 1;
    end
    if (cur_wr) begin
      exp_cyc = last + 1;
      return;
    end
    e = last + 1;
    cum = 0;
    for (int i = 0; i < cur_rxn && exp_cyc < 0; i++) begin
      cum += cur_dly[i];
      if (cum > TMO || (cum == TMO && i != NB - 1)) begin
        exp_cyc = e + i + TMO + 1;
        exp_err = 1'b1;
      end else if (i == NB - 1) begin
        exp_cyc  = e + i + cum + 1;
        exp_data = cur_rxw;
      end
    end
    if (exp_cyc < 0) begin
      exp_cyc = e + cur_rxn + TMO + 1;
      exp_err = 1'b1;
    end
  endfunction

  // Drives one request starting in the current cycle (already #1 after an edge)
  // and records what the DUT did. tmode: 0 tready high, 1 toggling, 2 random.
  task automatic run_txn(input bit wr, input logic [2:0] rg, input logic [31:0] wd,
                         input logic [31:0] rxw, input int rx_n,
                         input int d0, input int d1, input int d2, input int d3, input int tmode);
    bit tr, pend, tx_done;
    logic [7:0] pd;
    bit pl;
    int rx_i, gap, rsp_seen;
    cur_wr = wr; cur_rg = rg; cur_wd = wd; cur_rxw = rxw; cur_rxn = rx_n;
    cur_dly[0] = d0; cur_dly[1] = d1; cur_dly[2] = d2; cur_dly[3] = d3;
    tr_hist.delete();
    obs_frame = ""; obs_rsp_cyc = -1; obs_stall_bad = 0; obs_rsp_err = 1'b0; obs_rsp_data = 32'h0;
    pend = 1'b0; tx_done = 1'b0; pd = 8'h00; pl = 1'b0; rx_i = 0; gap = 0; rsp_seen = 0;
    obs_ready_t0 = bus.o_req_ready;
    bus.i_req_valid = 1'b1; bus.i_req_write = wr; bus.i_req_reg = rg; bus.i_req_wdata = wd;
    for (int k = 1; k <= 400 && rsp_seen == 0; k++) begin
      @(posedge clk); #1;
      bus.i_req_valid = 1'b0;
      if (k == 1) begin
        obs_ready_t1 = bus.o_req_ready; obs_tvalid_t1 = bus.o_tx_tvalid; obs_busy_t1 = bus.o_busy;
      end
      bus.i_rx_tvalid = 1'b0; bus.i_rx_tlast = 1'b0;
      if (tx_done && rx_i < rx_n) begin
        if (gap < cur_dly[rx_i]) gap++;
        else begin
          bus.i_rx_tvalid = 1'b1;
          bus.i_rx_tdata  = 8'(rxw >> (8 * (3 - rx_i)));
          bus.i_rx_tlast  = (rx_i == 3);
          if (bus.o_rx_tready) begin rx_i++; gap = 0; end
        end
      end
      case (tmode)
        0:       tr = 1'b1;
        1:       tr = ((k % 2) == 1);
        default: tr = 1'($urandom_range(0, 1));
      endcase
      tr_hist.push_back(tr);
      bus.i_tx_tready = tr;
      if (pend && !(bus.o_tx_tvalid === 1'b1 && bus.o_tx_tdata === pd && bus.o_tx_tlast === pl)) obs_stall_bad++;
      pend = bus.o_tx_tvalid && !tr; pd = bus.o_tx_tdata; pl = bus.o_tx_tlast;
      if (bus.o_tx_tvalid && tr) begin
        obs_frame = {obs_frame, $sformatf("%02h%s ", bus.o_tx_tdata, bus.o_tx_tlast ? "*" : "")};
        if (bus.o_tx_tlast) tx_done = 1'b1;
      end
      if (bus.o_rsp_valid) begin
        rsp_seen = 1; obs_rsp_cyc = k; obs_rsp_err = bus.o_rsp_error; obs_rsp_data = bus.o_rsp_rdata;
      end
    end
    bus.i_rx_tvalid = 1'b0; bus.i_rx_tlast = 1'b0; bus.i_tx_tready = 1'b1;
    @(posedge clk); #1;
    obs_after_valid = bus.o_rsp_valid; obs_after_ready = bus.o_req_ready; obs_after_data = bus.o_rsp_rdata;
    build_exp();
    $display("txn %s reg=%0d wdata=%h frame=[%s] rsp_cycle=%0d err=%0b rdata=%h",
             wr ? "WR" : "RD", rg, wd, obs_frame, obs_rsp_cyc, obs_rsp_err, obs_rsp_data);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.o_req_ready, bus.o_rx_tready, bus.o_tx_tvalid, bus.o_tx_tlast, bus.o_rsp_valid,
         bus.o_rsp_error, bus.o_busy, bus.o_tx_tdata, bus.o_rsp_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: outputs not all zero during reset (ready=%b tvalid=%b busy=%b)",
                         bus.o_req_ready, bus.o_tx_tvalid, bus.o_busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.o_req_ready, bus.o_rx_tready, bus.o_busy} !== 3'b110) begin
      n_fail++; $display("FAIL reset_release: ready/rx_ready/busy=%b required 110",
                         {bus.o_req_ready, bus.o_rx_tready, bus.o_busy});
    end
  endtask

  task automatic test_write();
    run_txn(1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (obs_frame != exp_frame) begin n_fail++; $display("FAIL write_frame: got [%s] required [%s]", obs_frame, exp_frame); end
    n_checks++; if (obs_rsp_cyc != exp_cyc) begin n_fail++; $display("FAIL write_rsp_cycle: got T+%0d required T+%0d", obs_rsp_cyc, exp_cyc); end
    n_checks++; if ({obs_rsp_err, obs_rsp_data} !== {exp_err, exp_data}) begin n_fail++; $display("FAIL write_result: got err=%b data=%h required err=%b data=%h", obs_rsp_err, obs_rsp_data, exp_err, exp_data); end
    n_checks++; if ({obs_ready_t0, obs_ready_t1, obs_tvalid_t1, obs_busy_t1} !== 4'b1011) begin n_fail++; $display("FAIL write_accept: ready@T,ready@T+1,tvalid@T+1,busy@T+1=%b required 1011", {obs_ready_t0, obs_ready_t1, obs_tvalid_t1, obs_busy_t1}); end
    n_checks++; if ({obs_after_valid, obs_after_ready} !== 2'b01) begin n_fail++; $display("FAIL write_done_pulse: after rsp valid/ready=%b required 01", {obs_after_valid, obs_after_ready}); end
  endtask

  task automatic test_read();
    run_txn(1'b0, 3'd1, 32'h0, 32'h12345678, 4, 0, 1, 0, 2, 0);
    n_checks++; if (obs_frame != exp_frame) begin n_fail++; $display("FAIL read_frame: got [%s] required [%s]", obs_frame, exp_frame); end
    n_checks++; if (obs_rsp_cyc != exp_cyc) begin n_fail++; $display("FAIL read_rsp_cycle: got T+%0d required T+%0d", obs_rsp_cyc, exp_cyc); end
    n_checks++; if ({obs_rsp_err, obs_rsp_data} !== {exp_err, exp_data}) begin n_fail++; $display("FAIL read_result: got err=%b data=%h required err=%b data=%h", obs_rsp_err, obs_rsp_data, exp_err, exp_data); end
    n_checks++; if (obs_after_data !== exp_data) begin n_fail++; $display("FAIL read_data_held: got %h required %h", obs_after_data, exp_data); end
  endtask

  task automatic test_backpressure();
    run_txn(1'b1, 3'd0, $urandom, 32'h0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (obs_frame != exp_frame) begin n_fail++; $display("FAIL bp_frame: got [%s] required [%s]", obs_frame, exp_frame); end
    n_checks++; if (obs_stall_bad != 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable stalled cycles, required 0", obs_stall_bad); end
    n_checks++; if (obs_rsp_cyc != exp_cyc) begin n_fail++; $display("FAIL bp_rsp_cycle: got T+%0d required T+%0d", obs_rsp_cyc, exp_cyc); end
  endtask

  task automatic test_bad_reg();
    for (int r = 4; r <= 7; r++) begin
      run_txn(1'($urandom_range(0, 1)), 3'(r), $urandom, 32'h0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs_frame != exp_frame || obs_tvalid_t1 !== 1'b0) begin n_fail++; $display("FAIL bad_reg_tx: reg %0d sent [%s] tvalid@T+1=%b required no bytes", r, obs_frame, obs_tvalid_t1); end
      n_checks++;
      if (obs_rsp_cyc != exp_cyc || obs_rsp_err !== exp_err || obs_rsp_data !== exp_data) begin
        n_fail++; $display("FAIL bad_reg_rsp: reg %0d got T+%0d err=%b data=%h required T+%0d err=%b data=%h",
                           r, obs_rsp_cyc, obs_rsp_err, obs_rsp_data, exp_cyc, exp_err, exp_data);
      end
    end
  endtask

  task automatic test_timeout();
    // empty RX stream, two bytes only, final byte coincident with expiry
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       run_txn(1'b0, 3'd3, 32'h0, $urandom, 0, 0, 0, 0, 0, 0);
        1:       run_txn(1'b0, 3'd2, 32'h0, $urandom, 2, 0, 0, 0, 0, 0);
        default: run_txn(1'b0, 3'd0, 32'h0, $urandom, 4, 0, 0, 0, TMO, 0);
      endcase
      n_checks++;
      if (obs_rsp_cyc != exp_cyc) begin n_fail++; $display("FAIL timeout_cycle_%0d: got T+%0d required T+%0d", t, obs_rsp_cyc, exp_cyc); end
      n_checks++;
      if ({obs_rsp_err, obs_rsp_data} !== {exp_err, exp_data}) begin
        n_fail++; $display("FAIL timeout_result_%0d: got err=%b data=%h required err=%b data=%h", t, obs_rsp_err, obs_rsp_data, exp_err, exp_data);
      end
    end
    run_txn(1'b1, 3'd1, $urandom, 32'h0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_ready_t0 !== 1'b1 || obs_frame != exp_frame || obs_rsp_cyc != exp_cyc || obs_rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_next_req: ready=%b frame [%s] T+%0d err=%b required [%s] T+%0d err=0",
                         obs_ready_t0, obs_frame, obs_rsp_cyc, obs_rsp_err, exp_frame, exp_cyc);
    end
  endtask

  task automatic test_reset_midframe();
    int pulses = 0;
    bus.i_req_valid = 1'b1; bus.i_req_write = 1'b1; bus.i_req_reg = 3'd3; bus.i_req_wdata = $urandom;
    bus.i_tx_tready = 1'b1;
    repeat (4) begin @(posedge clk); #1; bus.i_req_valid = 1'b0; end
    @(posedge clk); #1;
    rst = 1'b1; bus.i_tx_tready = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.o_tx_tvalid, bus.o_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL midreset_drop: tvalid/rsp_valid=%b required 00", {bus.o_tx_tvalid, bus.o_rsp_valid}); end
    rst = 1'b0; bus.i_tx_tready = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (bus.o_rsp_valid || bus.o_tx_tvalid) pulses++; end
    n_checks++;
    if (pulses != 0 || bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_quiet: %0d active cycles ready=%b required 0 and 1", pulses, bus.o_req_ready); end
    run_txn(1'b0, 3'd2, 32'h0, $urandom, 4, 1, 0, 2, 0, 0);
    n_checks++;
    if (obs_frame != exp_frame || obs_rsp_cyc != exp_cyc || {obs_rsp_err, obs_rsp_data} !== {exp_err, exp_data}) begin
      n_fail++; $display("FAIL midreset_read: got [%s] T+%0d err=%b data=%h required [%s] T+%0d err=%b data=%h",
                         obs_frame, obs_rsp_cyc, obs_rsp_err, obs_rsp_data, exp_frame, exp_cyc, exp_err, exp_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 30; n++) begin
      logic [2:0] rg;
      rg = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      run_txn(1'($urandom_range(0, 1)), rg, $urandom, $urandom, 4,
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 2);
      n_checks++;
      if (obs_ready_t0 !== 1'b1 || obs_frame != exp_frame || obs_stall_bad != 0) begin
        n_fail++; $display("FAIL b2b_frame_%0d: ready=%b stalls=%0d got [%s] required [%s]", n, obs_ready_t0, obs_stall_bad, obs_frame, exp_frame);
      end
      n_checks++;
      if (obs_rsp_cyc != exp_cyc || {obs_rsp_err, obs_rsp_data} !== {exp_err, exp_data}) begin
        n_fail++; $display("FAIL b2b_rsp_%0d: got T+%0d err=%b data=%h required T+%0d err=%b data=%h",
                           n, obs_rsp_cyc, obs_rsp_err, obs_rsp_data, exp_cyc, exp_err, exp_data);
      end
      n_checks++;
      if ({obs_after_valid, obs_after_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_pulse_%0d: after rsp valid/ready=%b required 01", n, {obs_after_valid, obs_after_ready}); end
    end
  endtask

  initial begin
    bus.i_req_valid = 1'b0; bus.i_req_write = 1'b0; bus.i_req_reg = 3'd0; bus.i_req_wdata = 32'h0;
    bus.i_tx_tready = 1'b1; bus.i_rx_tdata = 8'h00; bus.i_rx_tvalid = 1'b0; bus.i_rx_tlast = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_bad_reg();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
